// File: rtl/ps2_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_buffer
// Purpose  : Assembles decoded key codes into an editable line and hands
//            terminated lines to a consumer through a one-deep holding register.
// Revision : 1.0  initial release
// ============================================================================
module ps2_line_buffer #(
    parameter int         LINE_CHARS = 32,
    parameter logic [7:0] TERM_CHAR  = 8'h0A,
    parameter logic [7:0] BS_CHAR    = 8'h08
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              key_pressed,
    input  logic [7:0]                        ascii_char,
    input  logic                              line_ack,
    output logic [8*LINE_CHARS-1:0]           edit_content,
    output logic [$clog2(LINE_CHARS+1)-1:0]   edit_count,
    output logic [8*LINE_CHARS-1:0]           line_content,
    output logic [$clog2(LINE_CHARS+1)-1:0]   line_length,
    output logic                              line_valid,
    output logic                              line_overflow,
    output logic                              line_dropped
);

    localparam int             c_cnt_w     = $clog2(LINE_CHARS+1);
    localparam logic [c_cnt_w-1:0] c_max_count = c_cnt_w'(LINE_CHARS);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    // Slot 0 lives in the most significant byte (packed index LINE_CHARS-1).
    logic [LINE_CHARS-1:0][7:0]       edit_q, edit_d;
    logic [c_cnt_w-1:0]               count_q, count_d;
    logic                             ovf_q, ovf_d;
    logic [8*LINE_CHARS-1:0]          line_q, line_d;
    logic [c_cnt_w-1:0]               len_q, len_d;
    logic                             lovf_q, lovf_d;
    logic                             drop_q, drop_d;

    logic w_key, w_term, w_bs, w_print;

    assign w_key   = key_pressed && (ascii_char != 8'h00);
    assign w_term  = w_key && (ascii_char == TERM_CHAR);
    assign w_bs    = w_key && (ascii_char == BS_CHAR);
    assign w_print = w_key && !w_term && !w_bs;

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        line_d  = line_q;
        len_d   = len_q;
        lovf_d  = lovf_q;
        drop_d  = 1'b0;

        if (w_term) begin
            edit_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            // An ack in the same cycle frees the holder, so the new line fits.
            if ((state_q == EMPTY) || line_ack) begin
                line_d  = edit_q;
                len_d   = count_q;
                lovf_d  = ovf_q;
                state_d = FULL;
            end else begin
                drop_d  = 1'b1;
            end
        end else begin
            if ((state_q == FULL) && line_ack) begin
                state_d = EMPTY;
            end
            if (w_bs && (count_q != '0)) begin
                for (int i = 0; i < LINE_CHARS; i++) begin
                    if (c_cnt_w'(LINE_CHARS - 1 - i) == (count_q - c_cnt_w'(1))) begin
                        edit_d[i] = 8'h00;
                    end
                end
                count_d = count_q - c_cnt_w'(1);
            end
            if (w_print) begin
                if (count_q != c_max_count) begin
                    for (int i = 0; i < LINE_CHARS; i++) begin
                        if (c_cnt_w'(LINE_CHARS - 1 - i) == count_q) begin
                            edit_d[i] = ascii_char;
                        end
                    end
                    count_d = count_q + c_cnt_w'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            edit_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            line_q  <= '0;
            len_q   <= '0;
            lovf_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edit_q  <= edit_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            line_q  <= line_d;
            len_q   <= len_d;
            lovf_q  <= lovf_d;
            drop_q  <= drop_d;
        end
    end

    assign edit_content  = edit_q;
    assign edit_count    = count_q;
    assign line_content  = line_q;
    assign line_length   = len_q;
    assign line_valid    = (state_q == FULL);
    assign line_overflow = lovf_q;
    assign line_dropped  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_line_buffer
// Purpose  : Drives a 32-char and a 4-char line buffer with identical keys and
//            checks both against a character-array model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_line_buffer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       kp;
    logic [7:0] ch;
    logic       ack;

    logic [255:0] ec_a, lc_a;
    logic [5:0]   ecnt_a, ll_a;
    logic         lv_a, lo_a, ld_a;
    logic [31:0]  ec_b, lc_b;
    logic [2:0]   ecnt_b, ll_b;
    logic         lv_b, lo_b, ld_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ps2_line_buffer u_dut_a (
        .clock(clk), .resetn(resetn), .key_pressed(kp), .ascii_char(ch), .line_ack(ack),
        .edit_content(ec_a), .edit_count(ecnt_a), .line_content(lc_a), .line_length(ll_a),
        .line_valid(lv_a), .line_overflow(lo_a), .line_dropped(ld_a)
    );

    ps2_line_buffer #(.LINE_CHARS(4)) u_dut_b (
        .clock(clk), .resetn(resetn), .key_pressed(kp), .ascii_char(ch), .line_ack(ack),
        .edit_content(ec_b), .edit_count(ecnt_b), .line_content(lc_b), .line_length(ll_b),
        .line_valid(lv_b), .line_overflow(lo_b), .line_dropped(ld_b)
    );

    // Model: index 0 is the 32-char instance, index 1 the 4-char instance.
    logic [7:0]   m_edit [2][64];
    int           m_cnt  [2];
    bit           m_ovf  [2];
    bit           m_valid[2];
    bit           m_lovf [2];
    bit           m_drop [2];
    int           m_len  [2];
    logic [255:0] m_line [2];

    function automatic int cap(int m);
        return (m == 0) ? 32 : 4;
    endfunction

    function automatic logic [255:0] pack(int m);
        logic [255:0] v = '0;
        for (int i = 0; i < m_cnt[m]; i++) v[8*(cap(m)-1-i) +: 8] = m_edit[m][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 64; k++) m_edit[m][k] = 8'h00;
            m_cnt[m] = 0; m_ovf[m] = 0; m_valid[m] = 0; m_lovf[m] = 0;
            m_drop[m] = 0; m_len[m] = 0; m_line[m] = '0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            m_drop[m] = 0;
            if (kp && ch == 8'h0A) begin
                if (!m_valid[m] || ack) begin
                    m_line[m] = pack(m); m_len[m] = m_cnt[m];
                    m_lovf[m] = m_ovf[m]; m_valid[m] = 1;
                end else begin
                    m_drop[m] = 1;
                end
                for (int k = 0; k < 64; k++) m_edit[m][k] = 8'h00;
                m_cnt[m] = 0; m_ovf[m] = 0;
            end else begin
                if (m_valid[m] && ack) m_valid[m] = 0;
                if (kp && ch == 8'h08) begin
                    if (m_cnt[m] > 0) begin
                        m_cnt[m] = m_cnt[m] - 1;
                        m_edit[m][m_cnt[m]] = 8'h00;
                    end
                end else if (kp && ch != 8'h00) begin
                    if (m_cnt[m] < cap(m)) begin
                        m_edit[m][m_cnt[m]] = ch;
                        m_cnt[m] = m_cnt[m] + 1;
                    end else begin
                        m_ovf[m] = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A.edit_content", ec_a, pack(0));
            chk("A.edit_count", 256'(ecnt_a), 256'(m_cnt[0]));
            chk("A.line_content", lc_a, m_line[0]);
            chk("A.line_length", 256'(ll_a), 256'(m_len[0]));
            chk("A.line_valid", 256'(lv_a), 256'(m_valid[0]));
            chk("A.line_overflow", 256'(lo_a), 256'(m_lovf[0]));
            chk("A.line_dropped", 256'(ld_a), 256'(m_drop[0]));
            chk("B.edit_content", 256'(ec_b), pack(1));
            chk("B.edit_count", 256'(ecnt_b), 256'(m_cnt[1]));
            chk("B.line_content", 256'(lc_b), m_line[1]);
            chk("B.line_length", 256'(ll_b), 256'(m_len[1]));
            chk("B.line_valid", 256'(lv_b), 256'(m_valid[1]));
            chk("B.line_overflow", 256'(lo_b), 256'(m_lovf[1]));
            chk("B.line_dropped", 256'(ld_b), 256'(m_drop[1]));
        end
    end

    task automatic cyc(input logic k, input logic [7:0] c, input logic a);
        kp = k; ch = c; ack = a;
        @(posedge clk);
        model_step();
        #1;
        kp = 1'b0; ch = 8'h00; ack = 1'b0;
    endtask

    task automatic typ(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], 1'b0);
    endtask

    task automatic async_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst.A.line_valid", 256'(lv_a), 256'(0));
        chk("rst.A.edit_count", 256'(ecnt_a), 256'(0));
        chk("rst.A.edit_content", ec_a, 256'(0));
        chk("rst.A.line_content", lc_a, 256'(0));
        chk("rst.A.line_length", 256'(ll_a), 256'(0));
        chk("rst.B.line_overflow", 256'(lo_b), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] keys [6];
        keys[0] = 8'h61; keys[1] = 8'h62; keys[2] = 8'h08;
        keys[3] = 8'h0A; keys[4] = 8'h00; keys[5] = 8'h63;

        resetn = 1'b0; kp = 1'b0; ch = 8'h00; ack = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("reset.line_valid", 256'(lv_a), 256'(0));
        chk("reset.edit_count", 256'(ecnt_a), 256'(0));

        // Null key and keys without strobe change nothing.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h51, 1'b0);
        chk("null.edit_count", 256'(ecnt_a), 256'(0));

        typ("FIRE");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("fire.valid", 256'(lv_a), 256'(1));
        chk("fire.length", 256'(ll_a), 256'(4));
        chk("fire.top32", 256'(lc_a[255:224]), 256'(32'h46495245));
        chk("fire.rest", 256'(lc_a[223:0]), 256'(0));
        chk("fire.edit_count", 256'(ecnt_a), 256'(0));
        cyc(1'b0, 8'h00, 1'b1);
        chk("ack.valid", 256'(lv_a), 256'(0));
        chk("ack.retained", 256'(lc_a[255:224]), 256'(32'h46495245));

        typ("AB"); cyc(1'b1, 8'h08, 1'b0); typ("C");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("bs.length", 256'(ll_a), 256'(2));
        chk("bs.top16", 256'(lc_a[255:240]), 256'(16'h4143));
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h08, 1'b0);
        chk("bs_empty.edit_count", 256'(ecnt_a), 256'(0));

        typ("123456");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("ovf.B.length", 256'(ll_b), 256'(4));
        chk("ovf.B.content", 256'(lc_b), 256'(32'h31323334));
        chk("ovf.B.flag", 256'(lo_b), 256'(1));
        chk("ovf.A.length", 256'(ll_a), 256'(6));
        cyc(1'b0, 8'h00, 1'b1);
        typ("7");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("ovf2.B.flag", 256'(lo_b), 256'(0));
        cyc(1'b0, 8'h00, 1'b1);

        typ("X");
        cyc(1'b1, 8'h0A, 1'b0);
        typ("Y");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("drop.pulse", 256'(ld_a), 256'(1));
        chk("drop.kept", 256'(lc_a[255:248]), 256'(8'h58));
        cyc(1'b0, 8'h00, 1'b0);
        chk("drop.pulse_end", 256'(ld_a), 256'(0));
        typ("W");
        cyc(1'b1, 8'h0A, 1'b1);
        chk("ackterm.valid", 256'(lv_a), 256'(1));
        chk("ackterm.top8", 256'(lc_a[255:248]), 256'(8'h57));
        cyc(1'b0, 8'h00, 1'b1);

        cyc(1'b1, 8'h0A, 1'b0);
        chk("empty_line.valid", 256'(lv_a), 256'(1));
        chk("empty_line.length", 256'(ll_a), 256'(0));
        cyc(1'b0, 8'h00, 1'b1);

        typ("PQ");
        async_reset();
        typ("Z");
        cyc(1'b1, 8'h0A, 1'b0);
        chk("post_reset.length", 256'(ll_a), 256'(1));
        chk("post_reset.top8", 256'(lc_a[255:248]), 256'(8'h5A));
        async_reset();
        cyc(1'b0, 8'h00, 1'b1);

        for (int n = 0; n < 120; n++) begin
            cyc(1'($urandom_range(0, 3) != 0), keys[$urandom_range(0, 5)],
                1'($urandom_range(0, 4) == 0));
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
